// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL controller that borrows the shared EX-stage ALU.
// Produces the low DATA_WIDTH bits of in_a*in_b, one ALU op per granted cycle.
module alu_mul_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter logic [OPCODE_LENGTH-1:0] OP_ADD = 4'b0010,
  parameter logic [OPCODE_LENGTH-1:0] OP_SLL = 4'b0100,
  parameter logic [OPCODE_LENGTH-1:0] OP_SRL = 4'b0101
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_a,
  input  logic [DATA_WIDTH-1:0]    in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_result,
  output logic                     alu_req,
  input  logic                     alu_grant,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ONE =
    {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_result = '0;
    alu_req    = 1'b0;
    alu_op     = '0;
    alu_srca   = '0;
    alu_srcb   = '0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = in_a;
          mplier_d = in_b;
          acc_d    = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mplier_q == '0) state_d = S_DONE;
        else if (mplier_q[0]) state_d = S_ADD;
        else state_d = S_SHL;
      end
      S_ADD: begin
        alu_req  = 1'b1;
        alu_op   = OP_ADD;
        alu_srca = acc_q;
        alu_srcb = mcand_q;
        if (alu_grant) begin
          acc_d   = alu_result;
          state_d = S_SHL;
        end
      end
      S_SHL: begin
        alu_req  = 1'b1;
        alu_op   = OP_SLL;
        alu_srca = mcand_q;
        alu_srcb = ONE;
        if (alu_grant) begin
          mcand_d = alu_result;
          state_d = S_SHR;
        end
      end
      S_SHR: begin
        // logical shift guarantees mplier drains to zero
        alu_req  = 1'b1;
        alu_op   = OP_SRL;
        alu_srca = mplier_q;
        alu_srcb = ONE;
        if (alu_grant) begin
          mplier_d = alu_result;
          state_d  = S_CHECK;
        end
      end
      S_DONE: begin
        out_valid  = 1'b1;
        out_result = acc_q;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU
// and a plain-arithmetic product/latency reference.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        alu_req;
  logic        alu_grant;
  logic [3:0]  alu_op;
  logic [31:0] alu_srca, alu_srcb;
  logic [31:0] alu_result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ops[$];
  bit         req_seen;

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result),
    .alu_req(alu_req), .alu_grant(alu_grant),
    .alu_op(alu_op), .alu_srca(alu_srca),
    .alu_srcb(alu_srcb), .alu_result(alu_result)
  );

  always_comb begin
    case (alu_op)
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0100: alu_result = alu_srca << alu_srcb[4:0];
      4'b0101: alu_result = alu_srca >> alu_srcb[4:0];
      default: alu_result = 32'h0;
    endcase
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
    int l;
    l = 2;
    while (b != 0) begin
      l += 3 + int'(b[0]);
      b = b >> 1;
    end
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // gmode: 0 grant always, 1 random grant, 2 stall first SHL 5 cycles
  task automatic do_op(input logic [31:0] a, b, input int gmode,
                       input int hold, output logic [31:0] res,
                       output int lat);
    int stall;
    bit done;
    stall = 5;
    ops.delete();
    req_seen = 0;
    done = 0;
    @(negedge clk);
    chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    alu_grant = (gmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    lat = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      lat++;
      if (out_valid) done = 1;
      else begin
        if (alu_req) req_seen = 1;
        alu_grant = 1'b1;
        if (gmode == 1) alu_grant = ($urandom_range(0, 3) != 0);
        if (gmode == 2 && alu_req && alu_op == 4'h4 && stall > 0) begin
          alu_grant = 1'b0;
          stall--;
          chk("stall_srca", alu_srca, a);
          chk("stall_srcb", alu_srcb, 32'h1);
        end
        if (alu_req && alu_grant) ops.push_back(alu_op);
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no out_valid for a=%h b=%h", a, b);
      res = 'x;
      return;
    end
    res = out_result;
    chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_result", out_result, res);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", {31'h0, out_valid}, 32'h0);
    chk("post_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [3:0] exp_ops[8];
    logic [31:0] r, a, b;
    int l, gm;

    vt[0] = '{32'h3, 32'h5, 32'hF, 13};
    vt[1] = '{32'h1234, 32'h0, 32'h0, 2};
    vt[2] = '{32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 10};
    vt[3] = '{32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 130};
    vt[4] = '{32'h7, 32'h6, 32'h2A, 13};
    vt[5] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 99};
    exp_ops = '{4'h2, 4'h4, 4'h5, 4'h4, 4'h5, 4'h2, 4'h4, 4'h5};

    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    alu_grant = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_alu_req", {31'h0, alu_req}, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_srca", alu_srca, 32'h0);

    do_op(32'h3, 32'h5, 0, 0, r, l);
    chk("t2_result", r, 32'hF);
    chk("t2_lat", l, 32'd13);
    chk("t2_nops", ops.size(), 32'd8);
    for (int i = 0; i < 8 && i < ops.size(); i++)
      chk($sformatf("t2_op%0d", i), {28'h0, ops[i]}, {28'h0, exp_ops[i]});

    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].a, vt[i].b, 0, 0, r, l);
      chk($sformatf("vec%0d_result", i), r, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), l, vt[i].lat);
      chk($sformatf("vec%0d_req", i), {31'h0, req_seen},
          {31'h0, (vt[i].b != 0)});
    end

    do_op(32'h7, 32'h6, 2, 0, r, l);
    chk("t5_result", r, 32'd42);
    chk("t5_lat", l, 32'd18);

    do_op(32'h9, 32'hB, 0, 4, r, l);
    chk("t6_result", r, 32'd99);
    do_op(32'h5, 32'h5, 0, 0, r, l);
    chk("t6_next", r, 32'd25);

    @(negedge clk);
    in_a = 32'h3;
    in_b = 32'h5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_in_ready", {31'h0, in_ready}, 32'h1);
    chk("t1_out_valid", {31'h0, out_valid}, 32'h0);
    chk("t1_alu_req", {31'h0, alu_req}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit seen_valid;
      seen_valid = 0;
      repeat (20) begin
        @(negedge clk);
        if (out_valid) seen_valid = 1;
      end
      chk("t1_no_valid", {31'h0, seen_valid}, 32'h0);
    end
    do_op(32'hB, 32'hD, 0, 0, r, l);
    chk("t1_after", r, 32'd143);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      gm = (i % 2 == 0) ? 0 : 1;
      do_op(a, b, gm, 0, r, l);
      chk($sformatf("rnd%0d_result", i), r, ref_mul(a, b));
      if (gm == 0) chk($sformatf("rnd%0d_lat", i), l, ref_lat(b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
